// File: rtl/mpt_pkg.sv
// Shared MPT types and constants for the request arbiter slice.
//   arb_state_e     : arbiter output-register state (empty / holding a word).
//   mpt_req_id_t    : requester index, sized for the largest supported arbiter.
//   MPT_ARB_MAX_REQ : upper bound on requester ports of any arbiter instance.
package mpt_pkg;

  localparam int unsigned MPT_ARB_MAX_REQ  = 16;
  localparam int unsigned MPT_ARB_ID_WIDTH = $clog2(MPT_ARB_MAX_REQ);

  typedef logic [MPT_ARB_ID_WIDTH-1:0] mpt_req_id_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/mpt_rr_picker.sv
// Combinational round-robin picker.
// Returns the first set bit of valid_i, searching upward from ptr_i and wrapping
// back to bit 0.
//   valid_i  : request vector, NUM_REQ bits
//   ptr_i    : index with highest priority this cycle
//   winner_o : selected index (0 when nothing is found)
//   found_o  : high when any bit of valid_i is set
module mpt_rr_picker
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  mpt_req_id_t        ptr_i,
  output mpt_req_id_t        winner_o,
  output logic               found_o
);

  // Two passes instead of a modulo index: first the bits at or above the
  // pointer, then the wrapped-around bits below it.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!found_o && valid_i[k] && (k >= int'(ptr_i))) begin
        found_o  = 1'b1;
        winner_o = MPT_ARB_ID_WIDTH'(k);
      end
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!found_o && valid_i[k] && (k < int'(ptr_i))) begin
        found_o  = 1'b1;
        winner_o = MPT_ARB_ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/mpt_req_arbiter.sv
// Round-robin arbiter sharing the MPT pipeline fetch port among NUM_REQ
// requesters. The winning word is registered with its requester ID and held
// until the pipeline takes it. An outstanding-credit counter bounds the
// in-flight transactions; completions are routed back one-hot by ID.
//
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   enable_i             : allows new grants (a held word is always presented)
//   req_valid_i/data_i   : per-requester request; requester k in slice k
//   req_ready_o          : one-hot grant, combinational, in the accept cycle
//   pipe_valid_o/data_o/id_o, pipe_ready_i : registered pipeline-side handshake
//   cpl_valid_i, cpl_id_i: completion from the pipeline tail
//   cpl_valid_o          : completion demultiplexed to the issuing requester
//   outstanding_o        : transactions handed to the pipeline, not completed
//   busy_o               : word held or transactions outstanding
//
// Build option MPT_ARB_PERF_CNT_EN adds perf_grant_cnt_o (32-bit grant counter
// per requester) and perf_stall_cnt_o (cycles held without pipe_ready_i).
module mpt_req_arbiter
  import mpt_pkg::*;
#(
  parameter  int unsigned NUM_REQ         = 4,
  parameter  int unsigned DATA_WIDTH      = 32,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned ID_WIDTH        = $clog2(NUM_REQ),
  localparam int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          pipe_valid_o,
  output logic [DATA_WIDTH-1:0]         pipe_data_o,
  output logic [ID_WIDTH-1:0]           pipe_id_o,
  input  logic                          pipe_ready_i,
  input  logic                          cpl_valid_i,
  input  logic [ID_WIDTH-1:0]           cpl_id_i,
  output logic [NUM_REQ-1:0]            cpl_valid_o,
  output logic [CNT_WIDTH-1:0]          outstanding_o,
  output logic                          busy_o
`ifdef MPT_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_grant_cnt_o,
  output logic [31:0]                   perf_stall_cnt_o
`endif
);

  arb_state_e             state_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ID_WIDTH-1:0]    ptr_q;
  logic [CNT_WIDTH-1:0]   out_q, out_d;

  mpt_req_id_t            ptr_ext;
  mpt_req_id_t            winner;
  logic                   found;
  logic                   handshake;
  logic [31:0]            committed;
  logic                   credit_ok;
  logic                   accept;
  logic                   cpl_dec;
  logic [DATA_WIDTH-1:0]  win_data;

  assign ptr_ext = MPT_ARB_ID_WIDTH'(ptr_q);

  mpt_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid_i  (req_valid_i),
    .ptr_i    (ptr_ext),
    .winner_o (winner),
    .found_o  (found)
  );

  assign handshake = (state_q == ARB_HOLD) && pipe_ready_i;

  // A held word will consume a credit once it is taken, so it counts as
  // committed whether or not the handshake happens this cycle.
  assign committed = 32'(out_q) + 32'(state_q == ARB_HOLD);
  assign credit_ok = committed < MAX_OUTSTANDING;
  assign accept    = enable_i && found && credit_ok &&
                     ((state_q == ARB_IDLE) || handshake);

  // Completions arriving with nothing outstanding are dropped for counting.
  assign cpl_dec = cpl_valid_i && (out_q != '0);

  always_comb begin
    win_data    = '0;
    req_ready_o = '0;
    cpl_valid_o = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (int'(winner) == k) begin
        win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      // Gated by rst_i so grants and completions stay quiet during reset.
      req_ready_o[k] = accept && !rst_i && (int'(winner) == k);
      // IDs at or above NUM_REQ match no k and route nowhere.
      cpl_valid_o[k] = cpl_valid_i && !rst_i && (int'(cpl_id_i) == k);
    end
  end

  always_comb begin
    out_d = out_q;
    if (handshake && !cpl_dec) begin
      if (32'(out_q) < MAX_OUTSTANDING) begin
        out_d = out_q + CNT_WIDTH'(1);
      end
    end else if (!handshake && cpl_dec) begin
      out_d = out_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      out_q   <= '0;
    end else begin
      out_q <= out_d;
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            state_q <= ARB_HOLD;
            data_q  <= win_data;
            id_q    <= ID_WIDTH'(winner);
            ptr_q   <= ID_WIDTH'((32'(winner) + 32'd1) % NUM_REQ);
          end
        end
        ARB_HOLD: begin
          // accept here implies handshake: reload for back-to-back issue.
          if (accept) begin
            data_q <= win_data;
            id_q   <= ID_WIDTH'(winner);
            ptr_q  <= ID_WIDTH'((32'(winner) + 32'd1) % NUM_REQ);
          end else if (handshake) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign pipe_valid_o  = (state_q == ARB_HOLD);
  assign pipe_data_o   = data_q;
  assign pipe_id_o     = id_q;
  assign outstanding_o = out_q;
  assign busy_o        = pipe_valid_o || (out_q != '0);

`ifdef MPT_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        grant_cnt_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (accept && (int'(winner) == k)) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
        end
      end
      if ((state_q == ARB_HOLD) && !pipe_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    perf_grant_cnt_o = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      perf_grant_cnt_o[k*32 +: 32] = grant_cnt_q[k];
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
